// File: rtl/pc_sequencer_pkg.sv
// Shared encodings and constants for the program-counter sequencer.
// Imported by pc_sequencer and return_stack.
package pc_pkg;

  // next-PC mode select encodings; 6 and 7 fall back to sequential
  localparam logic [2:0] PC_SEQ    = 3'd0;
  localparam logic [2:0] PC_BRANCH = 3'd1;
  localparam logic [2:0] PC_JUMP   = 3'd2;
  localparam logic [2:0] PC_JREG   = 3'd3;
  localparam logic [2:0] PC_CALL   = 3'd4;
  localparam logic [2:0] PC_RET    = 3'd5;

  localparam logic [31:0] PC_RESET_VECTOR_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] PC_EXC_VECTOR_DEFAULT   = 32'h8000_0180;

  // word offsets become byte offsets by this shift
  localparam int unsigned INSTR_ALIGN_SHIFT = 2;

endpackage

// File: rtl/pc_sequencer_return_stack.sv
// Circular return-address stack: write pointer plus occupancy count.
// A push onto a full stack silently overwrites the oldest entry.
module return_stack
  import pc_pkg::*;
#(
  parameter int unsigned WSIZE     = 32,
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WSIZE-1:0] push_data,
  output logic [WSIZE-1:0] top,
  output logic             empty,
  output logic             full
);

  localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WSIZE-1:0] mem_q [RAS_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, top_ptr;
  logic [CNT_W-1:0] count_q, count_d;

  assign top_ptr = wr_ptr_q - PTR_W'(1);
  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(RAS_DEPTH));
  assign top     = empty ? '0 : mem_q[top_ptr];

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (!full) count_d = count_q + CNT_W'(1);
    end else if (pop && !empty) begin
      wr_ptr_d = top_ptr;
      count_d  = count_q - CNT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(negedge clock) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: the entry storage is deliberately not reset; an empty count masks stale contents.
  always_ff @(negedge clock) begin
    if (reset && push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter unit: holds the PC, selects the next PC from the mode,
// and handles exception redirect/EPC and the call/return address stack.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int unsigned      WSIZE        = 32,
  parameter logic [WSIZE-1:0] RESET_VECTOR = WSIZE'(PC_RESET_VECTOR_DEFAULT),
  parameter logic [WSIZE-1:0] EXC_VECTOR   = WSIZE'(PC_EXC_VECTOR_DEFAULT),
  parameter int unsigned      RAS_DEPTH    = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             stall,
  input  logic [2:0]       pc_sel,
  input  logic             branch_taken,
  input  logic [WSIZE-1:0] branch_offset,
  input  logic [25:0]      jump_index,
  input  logic [WSIZE-1:0] reg_target,
  input  logic             exception,
  input  logic             eret,
  output logic [WSIZE-1:0] pc,
  output logic [WSIZE-1:0] pc_plus4,
  output logic [WSIZE-1:0] epc,
  output logic [WSIZE-1:0] ras_top,
  output logic             ras_empty,
  output logic             ras_full,
  output logic             misaligned
);

  logic [WSIZE-1:0] pc_q, pc_d;
  logic [WSIZE-1:0] epc_q, epc_d;
  logic             misaligned_q, misaligned_d;
  logic             ras_push, ras_pop;
  logic [WSIZE-1:0] branch_target, jump_target, jreg_target;

  assign pc_plus4      = pc_q + WSIZE'(4);
  assign branch_target = pc_plus4 + (branch_offset << INSTR_ALIGN_SHIFT);
  assign jump_target   = {pc_plus4[WSIZE-1:28], jump_index, 2'b00};
  assign jreg_target   = {reg_target[WSIZE-1:2], 2'b00};

  assign pc         = pc_q;
  assign epc        = epc_q;
  assign misaligned = misaligned_q;

  // exception and eret take effect even while stalled
  always_comb begin
    pc_d         = pc_q;
    epc_d        = epc_q;
    misaligned_d = 1'b0;
    ras_push     = 1'b0;
    ras_pop      = 1'b0;
    if (exception) begin
      epc_d = pc_q;
      pc_d  = EXC_VECTOR;
    end else if (eret) begin
      pc_d = epc_q;
    end else if (!stall) begin
      case (pc_sel)
        PC_BRANCH: pc_d = branch_taken ? branch_target : pc_plus4;
        PC_JUMP:   pc_d = jump_target;
        PC_JREG: begin
          pc_d         = jreg_target;
          misaligned_d = |reg_target[1:0];
        end
        PC_CALL: begin
          pc_d     = jump_target;
          ras_push = 1'b1;
        end
        PC_RET: begin
          if (!ras_empty) begin
            pc_d    = ras_top;
            ras_pop = 1'b1;
          end else begin
            pc_d         = jreg_target;
            misaligned_d = |reg_target[1:0];
          end
        end
        default:   pc_d = pc_plus4;
      endcase
    end
  end

  always_ff @(negedge clock) begin
    if (!reset) begin
      pc_q         <= RESET_VECTOR;
      epc_q        <= '0;
      misaligned_q <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      epc_q        <= epc_d;
      misaligned_q <= misaligned_d;
    end
  end

  return_stack #(
    .WSIZE    (WSIZE),
    .RAS_DEPTH(RAS_DEPTH)
  ) u_return_stack (
    .clock    (clock),
    .reset    (reset),
    .push     (ras_push),
    .pop      (ras_pop),
    .push_data(pc_plus4),
    .top      (ras_top),
    .empty    (ras_empty),
    .full     (ras_full)
  );

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed plus randomized bench for pc_sequencer against a queue-based
// reference model; state changes on the falling edge, checks 1ns later.
module tb_pc_sequencer;

  localparam logic [31:0] RV  = 32'h0000_0000;
  localparam logic [31:0] EV  = 32'h8000_0180;
  localparam int          DEP = 4;

  logic        clock = 1'b0;
  logic        reset, stall, branch_taken, exception, eret;
  logic [2:0]  pc_sel;
  logic [31:0] branch_offset, reg_target;
  logic [25:0] jump_index;
  logic [31:0] pc, pc_plus4, epc, ras_top;
  logic        ras_empty, ras_full, misaligned;

  int total = 0;
  int bad   = 0;

  logic [31:0] m_pc, m_epc;
  logic        m_mis;
  logic [31:0] m_ras[$];

  pc_sequencer #(
    .WSIZE(32), .RESET_VECTOR(RV), .EXC_VECTOR(EV), .RAS_DEPTH(DEP)
  ) dut (
    .clock(clock), .reset(reset), .stall(stall), .pc_sel(pc_sel),
    .branch_taken(branch_taken), .branch_offset(branch_offset),
    .jump_index(jump_index), .reg_target(reg_target),
    .exception(exception), .eret(eret), .pc(pc), .pc_plus4(pc_plus4),
    .epc(epc), .ras_top(ras_top), .ras_empty(ras_empty),
    .ras_full(ras_full), .misaligned(misaligned)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // reference model: applies the documented rules to the sampled inputs
  task automatic model_step();
    logic [31:0] link;
    link = m_pc + 32'd4;
    if (!reset) begin
      m_pc = RV; m_epc = 32'd0; m_mis = 1'b0; m_ras.delete();
    end else if (exception) begin
      m_epc = m_pc; m_pc = EV; m_mis = 1'b0;
    end else if (eret) begin
      m_pc = m_epc; m_mis = 1'b0;
    end else if (stall) begin
      m_mis = 1'b0;
    end else begin
      m_mis = 1'b0;
      case (pc_sel)
        3'd1: m_pc = branch_taken ? link + branch_offset * 32'd4 : link;
        3'd2: m_pc = (link & 32'hF000_0000) | ({6'd0, jump_index} * 32'd4);
        3'd3: begin m_pc = reg_target & ~32'd3; m_mis = (reg_target % 4) != 0; end
        3'd4: begin
          m_ras.push_back(link);
          if (m_ras.size() > DEP) void'(m_ras.pop_front());
          m_pc = (link & 32'hF000_0000) | ({6'd0, jump_index} * 32'd4);
        end
        3'd5: begin
          if (m_ras.size() > 0) m_pc = m_ras.pop_back();
          else begin m_pc = reg_target & ~32'd3; m_mis = (reg_target % 4) != 0; end
        end
        default: m_pc = link;
      endcase
    end
  endtask

  task automatic tick();
    model_step();
    @(negedge clock);
    #1;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".pc"}, pc, m_pc);
    check({tag, ".pc_plus4"}, pc_plus4, m_pc + 32'd4);
    check({tag, ".epc"}, epc, m_epc);
    check({tag, ".ras_top"}, ras_top, (m_ras.size() > 0) ? m_ras[$] : 32'd0);
    check({tag, ".ras_empty"}, {31'd0, ras_empty}, {31'd0, m_ras.size() == 0});
    check({tag, ".ras_full"}, {31'd0, ras_full}, {31'd0, m_ras.size() == DEP});
    check({tag, ".misaligned"}, {31'd0, misaligned}, {31'd0, m_mis});
  endtask

  task automatic set_idle();
    reset = 1'b1; stall = 1'b0; exception = 1'b0; eret = 1'b0;
    pc_sel = 3'd0; branch_taken = 1'b0; branch_offset = 32'd0;
    jump_index = 26'd0; reg_target = 32'd0;
  endtask

  task automatic go_to(input logic [31:0] target);
    pc_sel = 3'd3; reg_target = target;
    tick();
    check_all("goto");
  endtask

  initial begin
    logic [31:0] ret_exp [4];
    logic [31:0] held_pc, held_top;
    ret_exp = '{32'h54, 32'h44, 32'h34, 32'h24};

    set_idle();
    #1;
    // reset held for two edges, then sequential fetch
    reset = 1'b0;
    tick(); check_all("rst_a"); check("rst_a.const", pc, 32'h0);
    tick(); check_all("rst_b");
    reset = 1'b1; pc_sel = 3'd0;
    tick(); check("seq1", pc, 32'h4);
    tick(); check("seq2", pc, 32'h8);
    tick(); check("seq3", pc, 32'hC); check_all("seq3");

    // branch taken and not taken
    go_to(32'h100);
    pc_sel = 3'd1; branch_offset = 32'hFFFF_FFFE; branch_taken = 1'b1;
    tick(); check("br_taken", pc, 32'hFC); check_all("br_taken");
    go_to(32'h100);
    pc_sel = 3'd1; branch_taken = 1'b0;
    tick(); check("br_not", pc, 32'h104); check_all("br_not");

    // jump, jump-register misalignment pulse
    go_to(32'h0040_0010);
    pc_sel = 3'd2; jump_index = 26'h10;
    tick(); check("jump", pc, 32'h40); check_all("jump");
    pc_sel = 3'd3; reg_target = 32'h203;
    tick(); check("jreg", pc, 32'h200); check("jreg.mis", {31'd0, misaligned}, 32'd1);
    pc_sel = 3'd0;
    tick(); check("jreg.mis_clr", {31'd0, misaligned}, 32'd0); check_all("jreg_after");

    // five nested calls overflow the four-entry stack
    go_to(32'h10);
    for (int i = 0; i < 5; i++) begin
      pc_sel = 3'd4; jump_index = 26'((32'h20 + 32'h10 * i) >> 2);
      tick(); check_all("call");
    end
    check("call.full", {31'd0, ras_full}, 32'd1);
    check("call.top", ras_top, 32'h54);
    for (int i = 0; i < 4; i++) begin
      pc_sel = 3'd5; reg_target = 32'h0;
      tick(); check("ret", pc, ret_exp[i]); check_all("ret");
    end
    check("ret.empty", {31'd0, ras_empty}, 32'd1);
    pc_sel = 3'd5; reg_target = 32'h700;
    tick(); check("ret_fallback", pc, 32'h700); check_all("ret_fallback");

    // exception overrides stall; eret returns to EPC
    go_to(32'h300);
    stall = 1'b1; exception = 1'b1;
    tick(); check("exc.epc", epc, 32'h300); check("exc.pc", pc, EV); check_all("exc");
    stall = 1'b0; exception = 1'b0; pc_sel = 3'd0;
    tick(); tick(); check("exc.seq", pc, 32'h8000_0188);
    eret = 1'b1;
    tick(); check("eret", pc, 32'h300); check_all("eret");
    eret = 1'b0;

    // stall holds everything; reset wins over stall
    pc_sel = 3'd4; jump_index = 26'h100;
    tick(); check_all("pre_stall");
    held_pc = pc; held_top = ras_top;
    stall = 1'b1; pc_sel = 3'd0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall.pc", pc, held_pc);
      check("stall.top", ras_top, held_top);
      check_all("stall");
    end
    reset = 1'b0;
    tick(); check("stall_rst.pc", pc, RV); check("stall_rst.empty", {31'd0, ras_empty}, 32'd1);
    check_all("stall_rst");
    set_idle();

    // randomized traffic
    for (int n = 0; n < 500; n++) begin
      reset         = ($urandom_range(0, 59) != 0);
      exception     = ($urandom_range(0, 24) == 0);
      eret          = ($urandom_range(0, 24) == 0);
      stall         = ($urandom_range(0, 4) == 0);
      pc_sel        = 3'($urandom_range(0, 7));
      branch_taken  = 1'($urandom_range(0, 1));
      branch_offset = 32'($urandom_range(0, 511)) - 32'd256;
      jump_index    = 26'($urandom);
      reg_target    = $urandom;
      tick();
      check_all("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
